// File: rtl/arb_pkg.sv
// arb_pkg: shared arbitration mode encoding and idle grant code helper
package arb_pkg;
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;
  function automatic logic [31:0] idle_code(input int idx_w);
    return 32'(1) << idx_w;
  endfunction
endpackage

// File: rtl/prio_scan.sv
// prio_scan: combinational highest-set-bit encoder returning {found, idx}
module prio_scan #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IDX_W = $clog2(N);
  assign found = |req;
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = req[i] ? IDX_W'(i) : idx;
  end
endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered fixed/round-robin priority arbiter with valid/ready output
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int N = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [N-1:0]       req,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [$clog2(N):0] out_idx,
  output logic [N-1:0]       out_onehot,
  output logic               out_multi
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W:0] IDLE = (IDX_W+1)'(idle_code(IDX_W));
  localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N - 1);
  logic               valid_q, valid_d, multi_q, multi_d;
  logic [IDX_W:0]     idx_q, idx_d;
  logic [N-1:0]       onehot_q, onehot_d, req_m;
  logic [IDX_W-1:0]   ptr_q, ptr_d, m_idx, u_idx, sel_idx, g;
  logic               m_found, u_found, ld, hs, rr;
  always_comb begin
    req_m = '0;
    for (int i = 0; i < N; i++) req_m[i] = req[i] && (IDX_W'(i) <= ptr_q);
  end
  prio_scan #(.N(N)) u_masked (.req(req_m), .found(m_found), .idx(m_idx));
  prio_scan #(.N(N)) u_full   (.req(req),   .found(u_found), .idx(u_idx));
  assign ld = !valid_q || out_ready;
  assign hs = valid_q && out_ready;
  assign rr = arb_mode_e'(mode) == MODE_RR;
  assign g  = idx_q[IDX_W-1:0];
  always_comb begin
    sel_idx  = (rr && m_found) ? m_idx : u_idx;
    valid_d  = ld ? u_found : valid_q;
    idx_d    = ld ? (u_found ? {1'b0, sel_idx} : IDLE) : idx_q;
    onehot_d = ld ? (u_found ? N'(1) << sel_idx : '0) : onehot_q;
    multi_d  = ld ? |(req & (req - 1'b1)) : multi_q;
    ptr_d    = (hs && rr) ? ((g == '0) ? PTR_TOP : g - 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= IDLE;
      onehot_q <= '0;
      multi_q  <= 1'b0;
      ptr_q    <= PTR_TOP;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
      ptr_q    <= ptr_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign out_multi  = multi_q;
endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: randomized and directed check of prio_arbiter against a behavioural model
module tb_prio_arbiter;
  localparam int N = 16;
  logic         clk = 1'b0, rst = 1'b1, mode = 1'b0, out_ready = 1'b0;
  logic [N-1:0] req = '0;
  logic         out_valid, out_multi;
  logic [4:0]   out_idx;
  logic [N-1:0] out_onehot;
  int           n_chk = 0, n_fail = 0;
  bit           mv, mm;
  int           mi, mp;
  prio_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .req(req), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .out_onehot(out_onehot), .out_multi(out_multi)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input bit rr, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = rr ? (p - k + N) % N : N - 1 - k;
      if (r[i]) return i;
    end
    return -1;
  endfunction
  task automatic step(input logic r_, input logic m_, input logic [N-1:0] q_, input logic rd_);
    int w, np;
    bit ld, hs;
    rst = r_; mode = m_; req = q_; out_ready = rd_;
    @(posedge clk);
    if (r_) begin
      mv = 0; mi = 0; mm = 0; mp = N - 1;
    end else begin
      ld = !mv || rd_;
      hs = mv && rd_;
      w  = pick(q_, m_, mp);
      np = (hs && m_) ? (mi == 0 ? N - 1 : mi - 1) : mp;
      if (ld) begin
        mv = w >= 0;
        mi = w >= 0 ? w : 0;
        mm = $countones(q_) > 1;
      end
      mp = np;
    end
    #1;
    chk("valid", 32'(out_valid), 32'(mv));
    chk("idx", 32'(out_idx), mv ? 32'(mi) : 32'd16);
    chk("onehot", 32'(out_onehot), mv ? 32'(1) << mi : 32'd0);
    chk("multi", 32'(out_multi), 32'(mm));
  endtask
  initial begin
    step(1, 0, '0, 1);
    chk("rst_idle", 32'(out_idx), 32'h10);
    step(0, 0, '0, 1);
    chk("idle_idx", 32'(out_idx), 32'h10);
    step(0, 0, 16'h0421, 1);
    chk("fix_idx", 32'(out_idx), 32'd10);
    chk("fix_oh", 32'(out_onehot), 32'h0400);
    chk("fix_multi", 32'(out_multi), 32'd1);
    step(0, 0, 16'h0001, 1);
    chk("fix_idx0", 32'(out_idx), 32'd0);
    chk("fix_single", 32'(out_multi), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 16'h8001, 1);
      chk("fix_hold15", 32'(out_idx), 32'd15);
    end
    for (int i = 0; i < 6; i++) step(0, 1, 16'h8001, 1);
    step(0, 1, 16'h0111, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0111, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'h0111, 1);
    step(0, 0, 16'h0100, 1);
    chk("stall_first", 32'(out_idx), 32'd8);
    step(0, 0, 16'h0002, 0);
    chk("stall_hold", 32'(out_idx), 32'd8);
    step(0, 0, 16'h0002, 1);
    chk("stall_next", 32'(out_idx), 32'd1);
    step(0, 1, 16'h0008, 0);
    step(1, 1, 16'h0008, 0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    step(0, 1, 16'h0009, 1);
    chk("rst_first_rr", 32'(out_idx), 32'd3);
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = $urandom_range(0, 3) == 0 ? '0 : N'($urandom & $urandom & $urandom);
      step($urandom_range(0, 49) == 0, 1'($urandom), r, $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
